mem_bus_arbiter: RTL and testbench

- Shares one variable-latency memory bus between the B32P instruction-fetch port (FE, read-only) and the data port (MEM stage, read/write).
- Sequences each access with a start/done handshake and returns data with one-cycle done pulses.
- Supports fetch cancellation on jumps and aborts hung accesses with a watchdog.
- The pipeline stall logic uses the done pulses and busy to derive stall_FE and stall_MEM.

---
 rtl/mem_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one variable-latency memory bus between the instruction-fetch port and
// the data port. Each access uses a start/done handshake and is guarded by a watchdog.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_done,
  output logic [DATA_W-1:0] i_q,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data,
  output logic              d_done,
  output logic [DATA_W-1:0] d_q,
  output logic              d_err,
  output logic              bus_start,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  input  logic              bus_done,
  input  logic [DATA_W-1:0] bus_q,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D} state_t;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              discard_q, discard_n;
  logic              bus_start_n, bus_we_n, busy_n;
  logic [ADDR_W-1:0] bus_addr_n;
  logic [DATA_W-1:0] bus_data_n, i_q_n, d_q_n;
  logic              i_done_n, i_err_n, d_done_n, d_err_n;
  logic              d_elig, i_elig;

  // A port whose done/err is still high has not yet dropped its request.
  assign d_elig = d_req && !d_done && !d_err;
  assign i_elig = i_req && !i_done && !i_err && !i_flush;

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    discard_n   = discard_q;
    bus_start_n = 1'b0;
    bus_we_n    = bus_we;
    bus_addr_n  = bus_addr;
    bus_data_n  = bus_data;
    i_q_n       = i_q;
    d_q_n       = d_q;
    i_done_n    = 1'b0;
    i_err_n     = 1'b0;
    d_done_n    = 1'b0;
    d_err_n     = 1'b0;
    case (state_q)
      IDLE: begin
        discard_n = 1'b0;
        if (d_elig) begin
          state_n     = BUS_D;
          bus_start_n = 1'b1;
          bus_we_n    = d_we;
          bus_addr_n  = d_addr;
          bus_data_n  = d_data;
          cnt_n       = '0;
        end else if (i_elig) begin
          state_n     = BUS_I;
          bus_start_n = 1'b1;
          bus_we_n    = 1'b0;
          bus_addr_n  = i_addr;
          bus_data_n  = '0;
          cnt_n       = '0;
        end
      end
      BUS_I, BUS_D: begin
        // A done coinciding with our own start pulse cannot belong to this access.
        if (bus_done && !bus_start) begin
          state_n   = IDLE;
          discard_n = 1'b0;
          if (state_q == BUS_D) begin
            d_q_n    = bus_q;
            d_done_n = 1'b1;
          end else if (!(discard_q || i_flush)) begin
            i_q_n    = bus_q;
            i_done_n = 1'b1;
          end
        end else if (WD_EN && (cnt_q == WD_LAST)) begin
          state_n   = IDLE;
          discard_n = 1'b0;
          i_err_n   = (state_q == BUS_I);
          d_err_n   = (state_q == BUS_D);
        end else begin
          cnt_n = cnt_q + 1'b1;
          if (state_q == BUS_I && i_flush) discard_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      discard_q <= 1'b0;
      bus_start <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_data  <= '0;
      i_q       <= '0;
      d_q       <= '0;
      i_done    <= 1'b0;
      i_err     <= 1'b0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      discard_q <= discard_n;
      bus_start <= bus_start_n;
      bus_we    <= bus_we_n;
      bus_addr  <= bus_addr_n;
      bus_data  <= bus_data_n;
      i_q       <= i_q_n;
      d_q       <= d_q_n;
      i_done    <= i_done_n;
      i_err     <= i_err_n;
      d_done    <= d_done_n;
      d_err     <= d_err_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a cycle table for fetch and contention, then
// hand-written sequences for flush, watchdog, reset and back-to-back fetches.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_flush, d_req, d_we, bus_done;
  logic [31:0] i_addr, d_addr, d_data, bus_q;
  logic        i_done, i_err, d_done, d_err, bus_start, bus_we, busy;
  logic [31:0] i_q, d_q, bus_addr, bus_data;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (bus_start) n_start <= n_start + 1;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_done(i_done), .i_q(i_q), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_data(d_data),
    .d_done(d_done), .d_q(d_q), .d_err(d_err),
    .bus_start(bus_start), .bus_we(bus_we), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_done(bus_done), .bus_q(bus_q), .busy(busy)
  );

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_data;
    logic        bus_done;
    logic [31:0] bus_q;
    logic        e_start;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_bdata;
    logic        e_idone;
    logic [31:0] e_iq;
    logic        e_ddone;
    logic [31:0] e_dq;
    logic        e_busy;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    reset = 1'b0; i_req = 0; i_addr = 0; i_flush = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_data = 0; bus_done = 0; bus_q = 0;
    tick(); tick();
    chk("rst_bus_start", {31'd0, bus_start}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_i_q", i_q, 0);
    chk("rst_d_q", d_q, 0);
    reset = 1'b1;
    tick();

    // i_req, i_addr, i_flush, d_req, d_we, d_addr, d_data, bus_done, bus_q,
    // start, we, addr, bdata, idone, iq, ddone, dq, busy
    vecs[0]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0,            1, 0, 32'h100, 0, 0, 0, 0, 0, 1};
    vecs[1]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0,            0, 0, 32'h100, 0, 0, 0, 0, 0, 1};
    vecs[2]  = '{1, 32'h100, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h100, 0, 1, 32'hDEADBEEF, 0, 0, 0};
    vecs[3]  = '{0, 32'h100, 0, 0, 0, 0, 0, 0, 0,            0, 0, 32'h100, 0, 0, 32'hDEADBEEF, 0, 0, 0};
    vecs[4]  = '{1, 32'h400, 0, 1, 1, 32'h20, 32'h55, 0, 0,  1, 1, 32'h20, 32'h55, 0, 32'hDEADBEEF, 0, 0, 1};
    vecs[5]  = '{1, 32'h400, 0, 1, 1, 32'h20, 32'h55, 0, 0,  0, 1, 32'h20, 32'h55, 0, 32'hDEADBEEF, 0, 0, 1};
    vecs[6]  = '{1, 32'h400, 0, 1, 1, 32'h20, 32'h55, 1, 32'h77, 0, 1, 32'h20, 32'h55, 0, 32'hDEADBEEF, 1, 32'h77, 0};
    vecs[7]  = '{1, 32'h400, 0, 1, 1, 32'h20, 32'h55, 0, 0,  1, 0, 32'h400, 0, 0, 32'hDEADBEEF, 0, 32'h77, 1};
    vecs[8]  = '{1, 32'h400, 0, 0, 0, 0, 0, 1, 32'hCAFE0001, 0, 0, 32'h400, 0, 0, 32'hDEADBEEF, 0, 32'h77, 1};
    vecs[9]  = '{1, 32'h400, 0, 0, 0, 0, 0, 1, 32'h12345678, 0, 0, 32'h400, 0, 1, 32'h12345678, 0, 32'h77, 0};
    vecs[10] = '{0, 32'h400, 0, 0, 0, 0, 0, 0, 0,            0, 0, 32'h400, 0, 0, 32'h12345678, 0, 32'h77, 0};

    s0 = n_start;
    for (int k = 0; k < 11; k++) begin
      if (k == 4) chk("fetch_start_count", n_start - s0, 1);
      if (k == 4) s0 = n_start;
      i_req = vecs[k].i_req; i_addr = vecs[k].i_addr; i_flush = vecs[k].i_flush;
      d_req = vecs[k].d_req; d_we = vecs[k].d_we; d_addr = vecs[k].d_addr;
      d_data = vecs[k].d_data; bus_done = vecs[k].bus_done; bus_q = vecs[k].bus_q;
      tick();
      chk($sformatf("v%0d_bus_start", k), {31'd0, bus_start}, {31'd0, vecs[k].e_start});
      chk($sformatf("v%0d_bus_we", k), {31'd0, bus_we}, {31'd0, vecs[k].e_we});
      chk($sformatf("v%0d_bus_addr", k), bus_addr, vecs[k].e_addr);
      chk($sformatf("v%0d_bus_data", k), bus_data, vecs[k].e_bdata);
      chk($sformatf("v%0d_i_done", k), {31'd0, i_done}, {31'd0, vecs[k].e_idone});
      chk($sformatf("v%0d_i_q", k), i_q, vecs[k].e_iq);
      chk($sformatf("v%0d_d_done", k), {31'd0, d_done}, {31'd0, vecs[k].e_ddone});
      chk($sformatf("v%0d_d_q", k), d_q, vecs[k].e_dq);
      chk($sformatf("v%0d_busy", k), {31'd0, busy}, {31'd0, vecs[k].e_busy});
      chk($sformatf("v%0d_errs", k), {30'd0, i_err, d_err}, 0);
    end
    chk("contention_start_count", n_start - s0, 2);

    // Flush while a fetch is in flight: the returned word is dropped.
    i_req = 1; i_addr = 32'h200; tick();
    chk("fl_start", {31'd0, bus_start}, 1);
    chk("fl_addr", bus_addr, 32'h200);
    i_flush = 1; tick();
    i_flush = 0; tick();
    bus_done = 1; bus_q = 32'h00000BAD; tick();
    chk("fl_no_done", {31'd0, i_done}, 0);
    chk("fl_iq_kept", i_q, 32'h12345678);
    chk("fl_idle", {31'd0, busy}, 0);
    // Flush in IDLE suppresses the grant for that cycle only.
    bus_done = 0; i_addr = 32'h300; i_flush = 1; tick();
    chk("fl_idle_suppress", {31'd0, bus_start}, 0);
    i_flush = 0; tick();
    chk("fl2_start", {31'd0, bus_start}, 1);
    chk("fl2_addr", bus_addr, 32'h300);
    tick();
    bus_done = 1; bus_q = 32'h00300300; tick();
    chk("fl2_done", {31'd0, i_done}, 1);
    chk("fl2_iq", i_q, 32'h00300300);
    bus_done = 0; i_req = 0; tick();

    // Watchdog: a read that never completes errors out 8 cycles after grant.
    d_req = 1; d_we = 0; d_addr = 32'h40; d_data = 0; tick();
    chk("wd_start", {31'd0, bus_start}, 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        if (d_err !== 1'b0 || busy !== 1'b1) chk($sformatf("wd_wait%0d", k), {30'd0, d_err, busy}, 1);
      end
    end
    chk("wd_err", {31'd0, d_err}, 1);
    chk("wd_busy", {31'd0, busy}, 0);
    chk("wd_no_done", {31'd0, d_done}, 0);
    chk("wd_dq_kept", d_q, 32'h77);
    d_req = 0; bus_done = 1; bus_q = 32'hFFFF; tick();
    chk("wd_late_done", {31'd0, d_done}, 0);
    chk("wd_late_dq", d_q, 32'h77);
    chk("wd_err_pulse", {31'd0, d_err}, 0);
    bus_done = 0; d_req = 1; d_we = 1; d_addr = 32'h44; d_data = 32'h99; tick();
    chk("wd2_we", {31'd0, bus_we}, 1);
    chk("wd2_data", bus_data, 32'h99);
    tick();
    bus_done = 1; bus_q = 32'hAB; tick();
    chk("wd2_done", {31'd0, d_done}, 1);
    chk("wd2_dq", d_q, 32'hAB);
    bus_done = 0; d_req = 0; tick();

    // Asynchronous reset in the middle of a data access.
    d_req = 1; d_we = 0; d_addr = 32'h50; tick(); tick();
    chk("rm_busy_before", {31'd0, busy}, 1);
    #2 reset = 1'b0;
    #1;
    chk("rm_busy", {31'd0, busy}, 0);
    chk("rm_bus_addr", bus_addr, 0);
    chk("rm_d_q", d_q, 0);
    chk("rm_i_q", i_q, 0);
    d_req = 0;
    @(negedge clk); reset = 1'b1;
    bus_done = 1; bus_q = 32'h5A5A; tick();
    chk("rm_stale_done", {30'd0, i_done, d_done}, 0);
    chk("rm_stale_busy", {31'd0, busy}, 0);
    bus_done = 0; tick();

    // Back-to-back fetches: no regrant in the i_done cycle.
    i_req = 1; i_addr = 32'h500; tick();
    tick();
    bus_done = 1; bus_q = 32'h5005; tick();
    chk("bb_done1", {31'd0, i_done}, 1);
    chk("bb_iq1", i_q, 32'h5005);
    bus_done = 0; i_addr = 32'h600; tick();
    chk("bb_no_start", {31'd0, bus_start}, 0);
    chk("bb_no_busy", {31'd0, busy}, 0);
    tick();
    chk("bb_start2", {31'd0, bus_start}, 1);
    chk("bb_addr2", bus_addr, 32'h600);
    tick();
    bus_done = 1; bus_q = 32'h6006; tick();
    chk("bb_done2", {31'd0, i_done}, 1);
    chk("bb_iq2", i_q, 32'h6006);
    bus_done = 0; i_req = 0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
